regfile_select_decoder: RTL and testbench
=========================================

// Module: regfile_select_decoder
// PURPOSE
//  Parametrised, registered SEL_W-to-2^SEL_W select decoder for the register file.
//  - Enable gating: G1 is active-high; each G2 bit disables the decoder when high.
//  - Two decode modes: level (hold) and one-cycle write-strobe (pulse).
//  - Sweep sequencer: walks every output in turn, e.g. to clear the register file after boot.
//  - Sits between the control unit and the register file's write/enable lines.
// PARAMETERS
//  SEL_W       3   select width; output count OUT_N = 2**SEL_W (SEL_W 1..6)
//  SWEEP_HOLD  1   cycles each output is held during a sweep (>=1)
// PORTS
//  clk          in   1      clock; all state changes on the rising edge
//  rst          in   1      synchronous reset, active-high
//  select       in   SEL_W  output index to decode
//  enableG1     in   1      active-high enable
//  enableG2     in   2      either bit high disables the decoder
//  pulse_mode   in   1      0 = level decode; 1 = one-cycle strobe per new select
//  sweep_start  in   1      request a full sweep (sampled in IDLE only)
//  out          out  OUT_N  registered one-hot select (polarity: see CONFIGURATION)
//  busy         out  1      high while a sweep is driving out
//  done         out  1      one-cycle pulse when a sweep completes
// BEHAVIOUR
//  - Reset: state=IDLE; out inactive (all 0, or all 1 when ACTIVE_LOW); busy=0; done=0;
//    hold counter, index counter, en_prev and sel_prev all cleared.
//    Reset mid-sweep aborts the sweep immediately; done does not pulse.
//  - en = enableG1 & ~enableG2[0] & ~enableG2[1].
//  - Latency is 1 cycle: inputs sampled at edge N appear on out after edge N.
//  - IDLE, pulse_mode=0: out = en ? onehot(select) : 0.
//  - IDLE, pulse_mode=1:
//    - evt = en & (~en_prev | (select != sel_prev)); out = evt ? onehot(select) : 0.
//    - A held enable with a stable select gives exactly one strobe.
//    - en_prev/sel_prev update every IDLE cycle in both modes, so switching modes
//      does not produce a spurious strobe.
//  - IDLE & sweep_start: go to SWEEP; index=0, hold=0.
//    - sweep_start takes priority over decode in the same cycle.
//    - out takes onehot(0) and busy=1 on the next edge.
//  - SWEEP:
//    - out = onehot(index); all decode inputs are ignored; sweep_start is ignored.
//    - hold counts 0..SWEEP_HOLD-1; at SWEEP_HOLD-1, hold wraps to 0 and index increments.
//    - After index OUT_N-1 completes its hold, go to DONE.
//  - DONE (one cycle): out inactive, busy=0, done=1; en_prev and sel_prev cleared.
//    - The next state is IDLE; normal decode resumes from the inputs sampled on that edge.
//    - A still-held enable therefore re-strobes once in pulse mode.
//  - Index counter is SEL_W bits and never wraps past OUT_N-1.
//    Hold counter is max(1, $clog2(SWEEP_HOLD)) bits.
//  - out is one-hot or all-inactive on every cycle; multiple active bits are never permitted.
// CONFIGURATION
//  - DECODER_ACTIVE_LOW_EN defined: out = ~out_q.
//    - Active output bit is 0; inactive/reset value is all 1s (74LS138-compatible pins).
//  - DECODER_ACTIVE_LOW_EN undefined: out = out_q.
//    - Active bit is 1; reset value is all 0s.
//  - Only output polarity changes; busy and done are always active-high.
// TESTING
//  1. Level: SEL_W=3, en=1, pulse_mode=0, select=5 held 3 cycles
//     -> out=8'b0010_0000 from the next edge on; G2=2'b01 -> out=0 next cycle.
//  2. Pulse: pulse_mode=1, en held, select 2,2,2,6
//     -> out=8'h04 for one cycle, then 0, 0, then 8'h40 for one cycle.
//  3. Sweep: SWEEP_HOLD=2, sweep_start pulse
//     -> out=01,01,02,02,...,80,80 (16 cycles) with busy=1;
//        then one cycle out=0, busy=0, done=1.
//  4. Priority: sweep_start with en=1, select=3 in the same cycle
//     -> next out=8'h01 (sweep), not 8'h08; sweep_start mid-sweep has no effect.
//  5. Reset mid-sweep: assert rst at index 4
//     -> next edge out=0, busy=0, done=0; state IDLE.
//  6. ACTIVE_LOW build: repeat test 1
//     -> out=8'b1101_1111; reset value 8'hFF; done/busy unchanged.

Source files
------------

// File: rtl/regfile_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_select_decoder
//  Purpose  : Registered SEL_W-to-2^SEL_W select decoder for the register file.
//             Decodes a select index into a one-hot write/enable line with
//             74LS138-style enable gating (G1 active-high, either G2 bit
//             disables). Two decode modes: level (hold) and a one-cycle write
//             strobe. A built-in sweep sequencer walks every output in turn,
//             holding each for SWEEP_HOLD cycles (e.g. register clear after
//             boot).
//
//  Parameters:
//    SEL_W       select width, output count OUT_N = 2**SEL_W (1..6)
//    SWEEP_HOLD  cycles each output is held during a sweep (>= 1)
//
//  Ports:
//    clk          in   1      clock, rising edge
//    rst          in   1      synchronous reset, active-high
//    select       in   SEL_W  output index to decode
//    enableG1     in   1      active-high enable
//    enableG2     in   2      either bit high disables the decoder
//    pulse_mode   in   1      0 = level decode, 1 = one strobe per new select
//    sweep_start  in   1      request a full sweep (honoured in IDLE only)
//    out          out  OUT_N  registered one-hot select
//    busy         out  1      high while a sweep drives out
//    done         out  1      one-cycle pulse when a sweep completes
//
//  Build option:
//    DECODER_ACTIVE_LOW_EN  when defined, out is active-low (inactive = all 1s).
//                           busy/done stay active-high.
//
//  Revision : 1.0  initial release
// ============================================================================
module regfile_select_decoder #(
    parameter int SEL_W      = 3,
    parameter int SWEEP_HOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        select,
    input  logic                    enableG1,
    input  logic [1:0]              enableG2,
    input  logic                    pulse_mode,
    input  logic                    sweep_start,
    output logic [(2**SEL_W)-1:0]   out,
    output logic                    busy,
    output logic                    done
);

    localparam int c_OUT_N  = 2**SEL_W;
    localparam int c_HOLD_W = (SWEEP_HOLD > 2) ? $clog2(SWEEP_HOLD) : 1;

    localparam logic [c_OUT_N-1:0]  c_ONE       = c_OUT_N'(1);
    localparam logic [SEL_W-1:0]    c_IDX_LAST  = SEL_W'(c_OUT_N - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(SWEEP_HOLD - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SWEEP = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]          r_state;
    logic [c_OUT_N-1:0]  r_out_q;
    logic                r_busy;
    logic                r_done;
    logic [c_HOLD_W-1:0] r_hold;
    logic [SEL_W-1:0]    r_index;
    logic                r_en_prev;
    logic [SEL_W-1:0]    r_sel_prev;

    logic                w_en;
    logic                w_evt;
    logic [c_OUT_N-1:0]  w_sel_oh;
    logic [c_OUT_N-1:0]  w_decode;
    logic [SEL_W-1:0]    w_idx_next;
    logic                w_hold_last;

    assign w_en     = enableG1 & ~enableG2[0] & ~enableG2[1];
    assign w_sel_oh = c_ONE << select;

    // A strobe fires on a rising enable or on any select change while enabled,
    // so a held enable with a stable select yields exactly one strobe.
    assign w_evt    = w_en & (~r_en_prev | (select != r_sel_prev));

    assign w_decode = pulse_mode ? (w_evt ? w_sel_oh : '0)
                                 : (w_en  ? w_sel_oh : '0);

    assign w_idx_next  = r_index + SEL_W'(1);
    assign w_hold_last = (r_hold == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_out_q    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hold     <= '0;
            r_index    <= '0;
            r_en_prev  <= 1'b0;
            r_sel_prev <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // History tracks every idle cycle in both modes so a mode
                    // switch never produces a spurious strobe.
                    r_en_prev  <= w_en;
                    r_sel_prev <= select;
                    r_done     <= 1'b0;
                    if (sweep_start) begin
                        r_state <= c_ST_SWEEP;
                        r_index <= '0;
                        r_hold  <= '0;
                        r_out_q <= c_ONE;
                        r_busy  <= 1'b1;
                    end else begin
                        r_out_q <= w_decode;
                        r_busy  <= 1'b0;
                    end
                end

                c_ST_SWEEP: begin
                    if (w_hold_last) begin
                        r_hold <= '0;
                        if (r_index == c_IDX_LAST) begin
                            r_state    <= c_ST_DONE;
                            r_out_q    <= '0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_en_prev  <= 1'b0;
                            r_sel_prev <= '0;
                        end else begin
                            r_index <= w_idx_next;
                            r_out_q <= c_ONE << w_idx_next;
                        end
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end

                c_ST_DONE: begin
                    // Decode resumes on the edge leaving DONE with cleared
                    // history, so a still-held enable re-strobes once.
                    r_state    <= c_ST_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_out_q    <= w_decode;
                    r_en_prev  <= w_en;
                    r_sel_prev <= select;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_out_q <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign out = ~r_out_q;
`else
    assign out = r_out_q;
`endif

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_select_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_select_decoder
//  Purpose  : Self-checking bench for regfile_select_decoder (SEL_W=3,
//             SWEEP_HOLD=2). Directed vectors push hand-computed expectations
//             into a queue; a monitor pops and compares after every edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_select_decoder;

    localparam int c_SEL_W = 3;
    localparam int c_OUT_N = 8;

    typedef struct {
        logic [c_OUT_N-1:0] out;
        logic               busy;
        logic               done;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [c_SEL_W-1:0] select = '0;
    logic               enableG1 = 1'b0;
    logic [1:0]         enableG2 = 2'b00;
    logic               pulse_mode = 1'b0;
    logic               sweep_start = 1'b0;
    logic [c_OUT_N-1:0] out;
    logic               busy;
    logic               done;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    regfile_select_decoder #(
        .SEL_W      (c_SEL_W),
        .SWEEP_HOLD (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .select      (select),
        .enableG1    (enableG1),
        .enableG2    (enableG2),
        .pulse_mode  (pulse_mode),
        .sweep_start (sweep_start),
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Expectations are written active-high; translate to pin polarity.
    function automatic logic [c_OUT_N-1:0] pol(input logic [c_OUT_N-1:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    // Drive one cycle of inputs and queue the response expected after the
    // next rising edge.
    task automatic cyc(input logic r, input logic g1, input logic [1:0] g2,
                       input logic pm, input logic ss, input logic [2:0] sel,
                       input logic [7:0] e_out, input logic e_busy,
                       input logic e_done);
        exp_t e;
        @(negedge clk);
        rst         = r;
        enableG1    = g1;
        enableG2    = g2;
        pulse_mode  = pm;
        sweep_start = ss;
        select      = sel;
        e.out  = e_out;
        e.busy = e_busy;
        e.done = e_done;
        q_exp.push_back(e);
    endtask

    // Monitor: one response per edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_vec++;
                if (out !== pol(e.out) || busy !== e.busy || done !== e.done) begin
                    n_err++;
                    $display("FAIL vec%0d: out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                             n_vec, out, busy, done, pol(e.out), e.busy, e.done);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(1, 0, 2'b00, 0, 0, 3'd0, 8'h00, 0, 0);
        cyc(1, 1, 2'b00, 0, 0, 3'd5, 8'h00, 0, 0);

        // Level decode, enable gating, boundary selects
        cyc(0, 1, 2'b00, 0, 0, 3'd5, 8'h20, 0, 0);
        cyc(0, 1, 2'b00, 0, 0, 3'd5, 8'h20, 0, 0);
        cyc(0, 1, 2'b00, 0, 0, 3'd5, 8'h20, 0, 0);
        cyc(0, 1, 2'b01, 0, 0, 3'd5, 8'h00, 0, 0);
        cyc(0, 1, 2'b10, 0, 0, 3'd5, 8'h00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 3'd5, 8'h00, 0, 0);
        cyc(0, 1, 2'b00, 0, 0, 3'd0, 8'h01, 0, 0);
        cyc(0, 1, 2'b00, 0, 0, 3'd7, 8'h80, 0, 0);

        // Pulse decode: 2,2,2,6 -> strobe, 0, 0, strobe
        cyc(0, 1, 2'b00, 1, 0, 3'd2, 8'h04, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd2, 8'h00, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd2, 8'h00, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd6, 8'h40, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd6, 8'h00, 0, 0);
        // Enable drop then rise re-strobes
        cyc(0, 0, 2'b00, 1, 0, 3'd6, 8'h00, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd6, 8'h40, 0, 0);
        // Mode switch level -> pulse with stable inputs: no spurious strobe
        cyc(0, 1, 2'b00, 0, 0, 3'd6, 8'h40, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd6, 8'h00, 0, 0);

        // Sweep with same-cycle decode request (sweep wins), sweep_start
        // re-asserted mid-sweep (ignored); each output held two cycles
        cyc(0, 1, 2'b00, 0, 1, 3'd3, 8'h01, 1, 0);
        for (int i = 1; i < 16; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << (i / 2);
            cyc(0, 1, 2'b00, 1, (i == 5) ? 1'b1 : 1'b0, 3'd3, oh, 1, 0);
        end
        cyc(0, 1, 2'b00, 1, 0, 3'd3, 8'h00, 0, 1);
        // Held enable re-strobes once after DONE
        cyc(0, 1, 2'b00, 1, 0, 3'd3, 8'h08, 0, 0);
        cyc(0, 1, 2'b00, 1, 0, 3'd3, 8'h00, 0, 0);

        // Reset in the middle of a sweep (at index 4)
        cyc(0, 0, 2'b00, 0, 1, 3'd0, 8'h01, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] oh;
            oh = 8'h01 << (i / 2);
            cyc(0, 0, 2'b00, 0, 0, 3'd0, oh, 1, 0);
        end
        cyc(1, 0, 2'b00, 0, 0, 3'd0, 8'h00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 3'd0, 8'h00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0, 3'd0, 8'h00, 0, 0);
        cyc(0, 1, 2'b00, 0, 0, 3'd1, 8'h02, 0, 0);

        @(posedge clk);
        #2;
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
